// File: rtl/mux_rr_arbiter_4ch.sv
// Round-robin arbiter sharing one registered 4-bit channel among four requesters.
// A hold limit forces rotation when the current owner keeps the channel while others wait.
module mux_rr_arbiter_4ch #(
  parameter int MAX_HOLD = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] req,
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic [3:0] c,
  input  logic [3:0] d,
  output logic [3:0] grant,
  output logic [1:0] sel,
  output logic [3:0] f,
  output logic       f_valid
);

  localparam logic [3:0] HOLD_LAST = 4'(MAX_HOLD - 1);

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  state_t     state_reg, state_next;
  logic [3:0] grant_reg, grant_next;
  logic [1:0] sel_reg, sel_next;
  logic [3:0] f_reg, f_next;
  logic       f_valid_reg, f_valid_next;
  logic [3:0] hold_cnt_reg, hold_cnt_next;
  logic [1:0] last_owner_reg, last_owner_next;

  logic [3:0] word_arr [4];
  logic [3:0] owner_onehot;
  logic [3:0] others;
  logic [1:0] idle_winner;
  logic [1:0] rot_winner;
  logic [3:0] idle_onehot;
  logic [3:0] rot_onehot;

  // First set bit of r, scanning upward from start with 3->0 wrap.
  function automatic logic [1:0] pick(input logic [3:0] r, input logic [1:0] start);
    logic [1:0] idx;
    logic       found;
    pick  = start;
    found = 1'b0;
    for (int k = 0; k < 4; k++) begin
      idx = start + 2'(k);
      if (!found && r[idx]) begin
        pick  = idx;
        found = 1'b1;
      end
    end
  endfunction

  assign word_arr[0] = a;
  assign word_arr[1] = b;
  assign word_arr[2] = c;
  assign word_arr[3] = d;

  // Owner is whoever sel points at while in GRANT.
  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_onehot
      assign owner_onehot[gi] = (sel_reg == 2'(gi));
      assign idle_onehot[gi]  = (idle_winner == 2'(gi));
      assign rot_onehot[gi]   = (rot_winner == 2'(gi));
    end
  endgenerate

  assign others      = req & ~owner_onehot;
  assign idle_winner = pick(req, last_owner_reg + 2'd1);
  assign rot_winner  = pick(others, sel_reg + 2'd1);

  always_comb begin
    state_next      = state_reg;
    grant_next      = grant_reg;
    sel_next        = sel_reg;
    f_next          = f_reg;
    f_valid_next    = 1'b0;
    hold_cnt_next   = hold_cnt_reg;
    last_owner_next = last_owner_reg;

    case (state_reg)
      IDLE: begin
        if (req != 4'b0000) begin
          grant_next      = idle_onehot;
          sel_next        = idle_winner;
          hold_cnt_next   = 4'd0;
          last_owner_next = idle_winner;
          state_next      = GRANT;
        end
      end
      GRANT: begin
        f_next       = word_arr[sel_reg];
        f_valid_next = 1'b1;
        if (!req[sel_reg] || (hold_cnt_reg == HOLD_LAST)) begin
          if (others != 4'b0000) begin
            grant_next      = rot_onehot;
            sel_next        = rot_winner;
            hold_cnt_next   = 4'd0;
            last_owner_next = rot_winner;
          end else if (!req[sel_reg]) begin
            grant_next = 4'b0000;
            state_next = IDLE;
          end
          // Lone owner at the limit: keep the grant with the counter saturated.
        end else begin
          hold_cnt_next = hold_cnt_reg + 4'd1;
        end
      end
      default: begin
        state_next = IDLE;
        grant_next = 4'b0000;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg      <= IDLE;
      grant_reg      <= 4'b0000;
      sel_reg        <= 2'd0;
      f_reg          <= 4'd0;
      f_valid_reg    <= 1'b0;
      hold_cnt_reg   <= 4'd0;
      last_owner_reg <= 2'd3;
    end else begin
      state_reg      <= state_next;
      grant_reg      <= grant_next;
      sel_reg        <= sel_next;
      f_reg          <= f_next;
      f_valid_reg    <= f_valid_next;
      hold_cnt_reg   <= hold_cnt_next;
      last_owner_reg <= last_owner_next;
    end
  end

  assign grant   = grant_reg;
  assign sel     = sel_reg;
  assign f       = f_reg;
  assign f_valid = f_valid_reg;

endmodule

// File: tb/tb_mux_rr_arbiter_4ch.sv
// Bench for mux_rr_arbiter_4ch: per-cycle comparison against a tenure-based model
// plus directed scenarios with literal expectations.
module tb_mux_rr_arbiter_4ch;
  localparam int MAX_HOLD = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] req = 4'b0000;
  logic [3:0] a = 4'd0, b = 4'd0, c = 4'd0, d = 4'd0;
  logic [3:0] grant;
  logic [1:0] sel;
  logic [3:0] f;
  logic       f_valid;

  int n_checks = 0;
  int n_errors = 0;

  mux_rr_arbiter_4ch #(.MAX_HOLD(MAX_HOLD)) dut (
    .clk(clk), .rst_n(rst_n), .req(req),
    .a(a), .b(b), .c(c), .d(d),
    .grant(grant), .sel(sel), .f(f), .f_valid(f_valid)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [7:0] actual, input logic [7:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Model: owner (-1 idle), tenure = cycles held so far, last owner for pointer.
  int         m_owner, m_tenure, m_last, m_sel, m_nxt;
  logic [3:0] m_f;
  logic       m_fv;

  function automatic logic [3:0] word_of(input int i);
    case (i)
      0: return a;
      1: return b;
      2: return c;
      default: return d;
    endcase
  endfunction

  function automatic int scan(input logic [3:0] r, input int start, input int skip);
    for (int k = 0; k < 4; k++) begin
      int j;
      j = (start + k) % 4;
      if (j != skip && r[j]) return j;
    end
    return -1;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_owner = -1; m_tenure = 0; m_last = 3; m_sel = 0; m_f = 4'd0; m_fv = 1'b0;
    end else begin
      if (m_owner >= 0) begin
        m_f  = word_of(m_owner);
        m_fv = 1'b1;
      end else begin
        m_fv = 1'b0;
      end
      if (m_owner < 0) begin
        if (req != 4'b0000) begin
          m_owner  = scan(req, m_last + 1, -1);
          m_tenure = 1;
        end
      end else begin
        m_nxt = scan(req, m_owner + 1, m_owner);
        if (!req[m_owner] || (m_tenure >= MAX_HOLD && m_nxt >= 0)) begin
          m_owner  = m_nxt;
          m_tenure = 1;
        end else if (m_tenure < MAX_HOLD) begin
          m_tenure++;
        end
      end
      if (m_owner >= 0) begin
        m_last = m_owner;
        m_sel  = m_owner;
      end
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (rst_n) begin
      check("m_grant", {4'd0, grant}, (m_owner < 0) ? 8'd0 : 8'(1 << m_owner));
      check("m_sel", {6'd0, sel}, 8'(m_sel));
      check("m_f_valid", {7'd0, f_valid}, {7'd0, m_fv});
      check("m_f", {4'd0, f}, {4'd0, m_f});
      check("onehot0", 8'($countones(grant) <= 1), 8'd1);
    end
  end

  task automatic do_reset();
    @(negedge clk); #1;
    rst_n = 1'b0;
    req   = 4'b0000;
    repeat (2) @(posedge clk);
    #1;
    check("rst_grant", {4'd0, grant}, 8'h00);
    check("rst_sel", {6'd0, sel}, 8'h00);
    check("rst_f", {4'd0, f}, 8'h00);
    check("rst_f_valid", {7'd0, f_valid}, 8'h00);
    @(negedge clk); #1;
    rst_n = 1'b1;
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  logic [3:0] pat_tbl [16] = '{4'b1111, 4'b1111, 4'b0101, 4'b0101, 4'b0101, 4'b0101,
                               4'b0101, 4'b1010, 4'b0000, 4'b0000, 4'b0010, 4'b1100,
                               4'b1100, 4'b1001, 4'b0110, 4'b0000};

  initial begin
    // Reset and first grant.
    do_reset();
    req = 4'b0001; a = 4'hA;
    step();
    check("first_grant", {4'd0, grant}, 8'h01);
    check("first_sel", {6'd0, sel}, 8'h00);
    check("first_fv_lag", {7'd0, f_valid}, 8'h00);
    step();
    check("first_f", {4'd0, f}, 8'h0A);
    check("first_fv", {7'd0, f_valid}, 8'h01);

    // Round-robin order, each owner held MAX_HOLD cycles.
    do_reset();
    req = 4'b1111; a = 4'd1; b = 4'd2; c = 4'd3; d = 4'd4;
    for (int cyc = 1; cyc <= 17; cyc++) begin
      step();
      check("rr_grant", {4'd0, grant}, 8'(1 << (((cyc - 1) / 4) % 4)));
      if (cyc >= 2) begin
        check("rr_f", {4'd0, f}, 8'((((cyc - 2) / 4) % 4) + 1));
        check("rr_fv", {7'd0, f_valid}, 8'h01);
      end
    end

    // Early release hands off with no idle gap.
    do_reset();
    a = 4'h5; b = 4'h6; c = 4'h7; d = 4'h8;
    req = 4'b0110;
    step();
    check("er_grant1", {4'd0, grant}, 8'h02);
    step();
    check("er_grant2", {4'd0, grant}, 8'h02);
    req = 4'b0100;
    step();
    check("er_grant3", {4'd0, grant}, 8'h04);
    check("er_sel3", {6'd0, sel}, 8'h02);
    check("er_fv3", {7'd0, f_valid}, 8'h01);
    check("er_f3", {4'd0, f}, 8'h06);
    step();
    check("er_fv4", {7'd0, f_valid}, 8'h01);
    check("er_f4", {4'd0, f}, 8'h07);

    // Lone requester keeps the grant, then rotation wraps to requester 0.
    do_reset();
    req = 4'b1000;
    for (int i = 0; i < 20; i++) begin
      step();
      check("lone_grant", {4'd0, grant}, 8'h08);
    end
    check("lone_hold_sat", {4'd0, dut.hold_cnt_reg}, 8'h03);
    req = 4'b1001;
    step();
    check("lone_rot_grant", {4'd0, grant}, 8'h01);
    check("lone_rot_sel", {6'd0, sel}, 8'h00);

    // Pointer after reset points past 3, so 0 wins over 3.
    do_reset();
    req = 4'b1001;
    step();
    check("wrap_grant", {4'd0, grant}, 8'h01);

    // Asynchronous reset mid-grant.
    do_reset();
    req = 4'b0100; c = 4'h9;
    step();
    check("ar_grant", {4'd0, grant}, 8'h04);
    step();
    check("ar_f", {4'd0, f}, 8'h09);
    #2 rst_n = 1'b0;
    #1;
    check("ar_grant0", {4'd0, grant}, 8'h00);
    check("ar_fv0", {7'd0, f_valid}, 8'h00);
    check("ar_f0", {4'd0, f}, 8'h00);
    check("ar_sel0", {6'd0, sel}, 8'h00);
    @(negedge clk); #1;
    rst_n = 1'b1;
    step();
    check("ar_regrant", {4'd0, grant}, 8'h04);
    check("ar_resel", {6'd0, sel}, 8'h02);

    // Mixed request patterns, checked by the model every cycle.
    do_reset();
    for (int i = 0; i < 16; i++) begin
      req = pat_tbl[i];
      a = 4'($urandom_range(15)); b = 4'($urandom_range(15));
      c = 4'($urandom_range(15)); d = 4'($urandom_range(15));
      repeat (3) step();
    end
    req = 4'b0000;
    repeat (3) step();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
